reg_dest_queue: RTL and testbench

Parametrised successor to the register-bank write-destination selector. It resolves the destination register index (rt/rd/rs/SP/RA) at issue time and queues it in an in-order reservation FIFO until the matching result arrives. It then drives a registered write port into the register bank. It also exports a busy mask so the control unit can stall on pending destinations.

---
 rtl/banco_pkg.sv | 39 +++
 rtl/dest_fifo.sv | 69 ++++++
 rtl/reg_dest_queue.sv | 115 +++++++++++
 tb/tb_reg_dest_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// Destination-select encodings, fixed register indices and the select resolver
// shared by the destination queue and its bench.
package banco_pkg;

   localparam logic [2:0] SEL_RT = 3'd0;
   localparam logic [2:0] SEL_RD = 3'd1;
   localparam logic [2:0] SEL_RS = 3'd2;
   localparam logic [2:0] SEL_SP = 3'd3;
   localparam logic [2:0] SEL_RA = 3'd4;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   typedef struct packed {
      logic        legal;
      logic [31:0] idx;
   } dest_res_t;

   // Fields arrive zero-extended to 32 bits; the caller truncates to AW.
   function automatic dest_res_t resolve_dest(input logic [2:0]  sel,
                                              input logic [31:0] rt,
                                              input logic [31:0] rd,
                                              input logic [31:0] rs);
      dest_res_t r;
      r.legal = 1'b1;
      r.idx   = 32'(REG_ZERO);
      case (sel)
         SEL_RT:  r.idx = rt;
         SEL_RD:  r.idx = rd;
         SEL_RS:  r.idx = rs;
         SEL_SP:  r.idx = 32'(REG_SP);
         SEL_RA:  r.idx = 32'(REG_RA);
         default: r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dest_fifo.sv
// In-order circular buffer of register indices with per-entry valid/index taps.
// Push/pop take effect at the next edge; caller must not push when full or pop when empty.
module dest_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [AW-1:0]             push_idx,
   input  logic                      pop,
   output logic [AW-1:0]             head_idx,
   output logic [CW-1:0]             count,
   output logic                      full,
   output logic                      empty,
   output logic [DEPTH-1:0]          entry_vld,
   output logic [DEPTH-1:0][AW-1:0]  entry_idx
);

   logic [DEPTH-1:0][AW-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]         vld_q, vld_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_idx;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      // Push and pop never share a slot: that would need count 0 or DEPTH.
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_idx  = mem_q[rd_ptr_q];
   assign count     = cnt_q;
   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign entry_vld = vld_q;
   assign entry_idx = mem_q;

endmodule

// File: rtl/reg_dest_queue.sv
// Reserves write destinations at issue, writes results back in order one cycle after wb handshake.
// issue_ready = !full; issues while full are dropped, wb while empty flags underflow.
module reg_dest_queue
   import banco_pkg::*;
#(
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [2:0]                  sel,
   input  logic [AW-1:0]               rt,
   input  logic [AW-1:0]               rd,
   input  logic [AW-1:0]               rs,
   input  logic                        issue,
   output logic                        issue_ready,
   input  logic                        wb_valid,
   input  logic [DW-1:0]               wb_data,
   output logic                        reg_we,
   output logic [AW-1:0]               reg_waddr,
   output logic [DW-1:0]               reg_wdata,
   output logic [(1<<AW)-1:0]          busy_mask,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic                        full,
   output logic                        empty,
   output logic                        err_illegal,
   output logic                        err_underflow
);

   localparam int CW = $clog2(DEPTH + 1);

   dest_res_t                res;
   logic [AW-1:0]            dest_idx;
   logic                     push, pop;
   logic [AW-1:0]            head_idx;
   logic [DEPTH-1:0]         entry_vld;
   logic [DEPTH-1:0][AW-1:0] entry_idx;
   logic [CW-1:0]            fifo_count;
   logic                     fifo_full, fifo_empty;

   logic          reg_we_q, reg_we_d;
   logic [AW-1:0] reg_waddr_q, reg_waddr_d;
   logic [DW-1:0] reg_wdata_q, reg_wdata_d;
   logic          err_illegal_q, err_illegal_d;
   logic          err_underflow_q, err_underflow_d;

   always_comb begin
      res      = resolve_dest(sel, 32'(rt), 32'(rd), 32'(rs));
      dest_idx = res.idx[AW-1:0];
      push     = issue && !fifo_full && res.legal;
      pop      = wb_valid && !fifo_empty;
   end

   dest_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_idx  (dest_idx),
      .pop       (pop),
      .head_idx  (head_idx),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .entry_vld (entry_vld),
      .entry_idx (entry_idx)
   );

   always_comb begin
      reg_we_d        = pop && (head_idx != AW'(REG_ZERO));
      reg_waddr_d     = reg_waddr_q;
      reg_wdata_d     = reg_wdata_q;
      if (pop) begin
         reg_waddr_d = head_idx;
         reg_wdata_d = wb_data;
      end
      err_illegal_d   = issue && !res.legal;
      err_underflow_d = wb_valid && fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_we_q        <= 1'b0;
         reg_waddr_q     <= '0;
         reg_wdata_q     <= '0;
         err_illegal_q   <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         reg_we_q        <= reg_we_d;
         reg_waddr_q     <= reg_waddr_d;
         reg_wdata_q     <= reg_wdata_d;
         err_illegal_q   <= err_illegal_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   // Duplicate destinations simply OR together, so a bit stays set until its last entry pops.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i]) busy_mask[entry_idx[i]] = 1'b1;
      end
   end

   assign issue_ready   = !fifo_full;
   assign count         = fifo_count;
   assign full          = fifo_full;
   assign empty         = fifo_empty;
   assign reg_we        = reg_we_q;
   assign reg_waddr     = reg_waddr_q;
   assign reg_wdata     = reg_wdata_q;
   assign err_illegal   = err_illegal_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_dest_queue.sv
// Directed bench for reg_dest_queue with default parameters (AW=5, DW=32, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_reg_dest_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  sel;
   logic [4:0]  rt, rd, rs;
   logic        issue;
   logic        issue_ready;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic [31:0] busy_mask;
   logic [2:0]  count;
   logic        full, empty;
   logic        err_illegal, err_underflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_dest_queue #(.AW(5), .DW(32), .DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .sel           (sel),
      .rt            (rt),
      .rd            (rd),
      .rs            (rs),
      .issue         (issue),
      .issue_ready   (issue_ready),
      .wb_valid      (wb_valid),
      .wb_data       (wb_data),
      .reg_we        (reg_we),
      .reg_waddr     (reg_waddr),
      .reg_wdata     (reg_wdata),
      .busy_mask     (busy_mask),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .err_illegal   (err_illegal),
      .err_underflow (err_underflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; sel = 3'd0; rt = '0; rd = '0; rs = '0;
      issue = 1'b0; wb_valid = 1'b0; wb_data = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", 64'(busy_mask), 64'h0);
      chk("rst_empty", 64'(empty), 64'h1);
      chk("rst_full", 64'(full), 64'h0);
      chk("rst_ready", 64'(issue_ready), 64'h1);
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_we", 64'(reg_we), 64'h0);
      chk("rst_waddr", 64'(reg_waddr), 64'h0);
      chk("rst_wdata", 64'(reg_wdata), 64'h0);
      chk("rst_errs", 64'({err_illegal, err_underflow}), 64'h0);

      // Single reservation to rd=8
      sel = 3'd1; rd = 5'd8; issue = 1'b1; tick(); issue = 1'b0;
      chk("t1_busy8", 64'(busy_mask), 64'h0000_0100);
      chk("t1_count", 64'(count), 64'h1);
      wb_valid = 1'b1; wb_data = 32'hDEADBEEF; tick(); wb_valid = 1'b0;
      chk("t1_we", 64'(reg_we), 64'h1);
      chk("t1_waddr", 64'(reg_waddr), 64'd8);
      chk("t1_wdata", 64'(reg_wdata), 64'hDEADBEEF);
      chk("t1_busy_clr", 64'(busy_mask), 64'h0);
      chk("t1_empty", 64'(empty), 64'h1);
      tick();
      chk("t1_we_pulse", 64'(reg_we), 64'h0);

      // SP, RA, then rt=0
      sel = 3'd3; issue = 1'b1; tick();
      sel = 3'd4; tick();
      sel = 3'd0; rt = 5'd0; tick(); issue = 1'b0;
      chk("t2_count", 64'(count), 64'd3);
      chk("t2_busy", 64'(busy_mask), 64'hA000_0001);
      wb_valid = 1'b1; wb_data = 32'd1; tick();
      chk("t2_w1", 64'({reg_we, reg_waddr, reg_wdata}), {31'd0, 1'b1, 5'd29, 32'd1});
      wb_data = 32'd2; tick();
      chk("t2_w2", 64'({reg_we, reg_waddr, reg_wdata}), {31'd0, 1'b1, 5'd31, 32'd2});
      wb_data = 32'd3; tick(); wb_valid = 1'b0;
      chk("t2_w3_no_we", 64'(reg_we), 64'h0);
      chk("t2_empty", 64'(empty), 64'h1);

      // Fill with rs=5, then overflow attempts carrying rs=9
      sel = 3'd2; rs = 5'd5; issue = 1'b1;
      tick(); tick(); tick(); tick();
      chk("t3_full", 64'(full), 64'h1);
      chk("t3_ready", 64'(issue_ready), 64'h0);
      chk("t3_count4", 64'(count), 64'd4);
      rs = 5'd9; tick();
      chk("t3_drop_count", 64'(count), 64'd4);
      chk("t3_drop_busy", 64'(busy_mask), 64'h0000_0020);
      wb_valid = 1'b1; wb_data = 32'h55; tick(); issue = 1'b0;
      chk("t3_sim_write", 64'({reg_we, reg_waddr, reg_wdata}), {31'd0, 1'b1, 5'd5, 32'h55});
      chk("t3_sim_count", 64'(count), 64'd3);
      chk("t3_sim_busy", 64'(busy_mask), 64'h0000_0020);
      tick(); tick(); tick(); wb_valid = 1'b0;
      chk("t3_drained", 64'(empty), 64'h1);

      // Duplicate destination 7
      sel = 3'd0; rt = 5'd7; issue = 1'b1; tick(); tick(); issue = 1'b0;
      chk("t4_busy_dup", 64'(busy_mask), 64'h0000_0080);
      wb_valid = 1'b1; wb_data = 32'h77; tick();
      chk("t4_busy_held", 64'(busy_mask), 64'h0000_0080);
      chk("t4_write", 64'({reg_we, reg_waddr}), {58'd0, 1'b1, 5'd7});
      tick(); wb_valid = 1'b0;
      chk("t4_busy_clr", 64'(busy_mask), 64'h0);

      // Illegal select and underflow
      sel = 3'd6; issue = 1'b1; tick(); issue = 1'b0;
      chk("t5_illegal", 64'(err_illegal), 64'h1);
      chk("t5_ill_count", 64'(count), 64'h0);
      tick();
      chk("t5_illegal_pulse", 64'(err_illegal), 64'h0);
      wb_valid = 1'b1; tick(); wb_valid = 1'b0;
      chk("t5_underflow", 64'(err_underflow), 64'h1);
      chk("t5_uf_we", 64'(reg_we), 64'h0);
      chk("t5_uf_empty", 64'(empty), 64'h1);
      tick();
      chk("t5_underflow_pulse", 64'(err_underflow), 64'h0);

      // No bypass: issue accepted alongside wb while empty
      sel = 3'd1; rd = 5'd3; issue = 1'b1; wb_valid = 1'b1; wb_data = 32'hAB; tick();
      issue = 1'b0;
      chk("t5b_no_bypass_we", 64'(reg_we), 64'h0);
      chk("t5b_uf", 64'(err_underflow), 64'h1);
      chk("t5b_count", 64'(count), 64'h1);
      tick(); wb_valid = 1'b0;
      chk("t5b_write", 64'({reg_we, reg_waddr, reg_wdata}), {31'd0, 1'b1, 5'd3, 32'hAB});

      // Reset mid-operation with a writeback in the reset cycle
      sel = 3'd1; issue = 1'b1;
      rd = 5'd10; tick(); rd = 5'd11; tick(); rd = 5'd12; tick(); issue = 1'b0;
      chk("t6_pre_count", 64'(count), 64'd3);
      reset = 1'b1; wb_valid = 1'b1; wb_data = 32'h99; tick();
      reset = 1'b0; wb_valid = 1'b0;
      chk("t6_rst_we", 64'(reg_we), 64'h0);
      chk("t6_rst_count", 64'(count), 64'h0);
      chk("t6_rst_busy", 64'(busy_mask), 64'h0);
      for (int k = 0; k < 6; k++) begin
         rd = 5'(16 + k); issue = 1'b1; tick(); issue = 1'b0;
         wb_valid = 1'b1; wb_data = 32'(100 + k); tick(); wb_valid = 1'b0;
         chk($sformatf("t6_wrap%0d", k), 64'({reg_we, reg_waddr, reg_wdata}),
             {31'd0, 1'b1, 5'(16 + k), 32'(100 + k)});
      end
      chk("t6_end_empty", 64'(empty), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
